// File: rtl/imem_responder.sv
// Instruction-memory responder: a byte-stream load port fills an internal RAM,
// then the block serves CPU fetches with one-cycle latency while holding run high.
module imem_responder #(
  parameter int              AW  = 8,
  parameter int              DW  = 8,
  parameter logic [DW-1:0]   NOP = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_ack,
  output logic [DW-1:0] fetch_data,
  output logic          fetch_oob,
  output logic          run,
  output logic [AW:0]   prog_len
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  localparam logic [AW-1:0] PTR_MAX = '1;

  logic [DW-1:0] mem_q [2**AW];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] data_q, data_d;
  logic          oob_q, oob_d;

  logic xfer;
  logic ptr_full;
  logic fetch_in_range;

  // A restart request outranks a same-cycle load beat, which is dropped.
  assign xfer           = (state_q == S_LOAD) && load_valid && !load_start;
  assign ptr_full       = (wr_ptr_q == PTR_MAX);
  assign fetch_in_range = ({1'b0, fetch_addr} < prog_len_q);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    ack_d      = 1'b0;
    oob_d      = 1'b0;
    data_d     = data_q;

    if (state_q == S_RUN && fetch_req && !load_start) begin
      ack_d  = 1'b1;
      oob_d  = !fetch_in_range;
      data_d = fetch_in_range ? mem_q[fetch_addr] : NOP;
    end

    if (load_start) begin
      state_d    = S_LOAD;
      wr_ptr_d   = '0;
      prog_len_d = '0;
    end else if (xfer) begin
      // A full RAM ends the image even without load_last; the pointer never wraps.
      if (load_last || ptr_full) begin
        prog_len_d = {1'b0, wr_ptr_q} + (AW+1)'(1);
        state_d    = S_RUN;
      end
      if (!ptr_full) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      ack_q      <= 1'b0;
      data_q     <= '0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      oob_q      <= oob_d;
    end
  end

  // RAM carries no reset; prog_len guards every read against unwritten entries.
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem_q[wr_ptr_q] <= load_data;
    end
  end

  assign load_ready = (state_q == S_LOAD);
  assign run        = (state_q == S_RUN);
  assign prog_len   = prog_len_q;
  assign fetch_ack  = ack_q;
  assign fetch_data = data_q;
  assign fetch_oob  = oob_q;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized bench for imem_responder against a cycle-level behavioural model
// built from the load/fetch rules (mode, word count, image array).
module tb_imem_responder;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam logic [DW-1:0] NOP = 8'h00;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [DW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_ack;
  logic [DW-1:0] fetch_data;
  logic          fetch_oob;
  logic          run;
  logic [AW:0]   prog_len;

  imem_responder #(.AW(AW), .DW(DW), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data), .fetch_oob(fetch_oob),
    .run(run), .prog_len(prog_len)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: 0 = empty, 1 = loading, 2 = running.
  int          m_mode;
  int          m_count;
  int          m_len;
  logic [7:0]  m_img [DEPTH];
  logic        m_ack;
  logic [7:0]  m_data;
  logic        m_oob;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".run"},        32'(run),        32'(m_mode == 2));
    chk({tag, ".load_ready"}, 32'(load_ready), 32'(m_mode == 1));
    chk({tag, ".prog_len"},   32'(prog_len),   32'(m_len));
    chk({tag, ".ack"},        32'(fetch_ack),  32'(m_ack));
    chk({tag, ".oob"},        32'(fetch_oob),  32'(m_oob));
    chk({tag, ".data"},       32'(fetch_data), 32'(m_data));
  endtask

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_len = 0;
    m_ack = 1'b0; m_data = 8'h00; m_oob = 1'b0;
  endtask

  task automatic model_clock();
    int a;
    a = int'(fetch_addr);
    if (load_start) begin
      m_mode = 1; m_count = 0; m_len = 0;
      m_ack = 1'b0; m_oob = 1'b0;
    end else if (m_mode == 1) begin
      m_ack = 1'b0; m_oob = 1'b0;
      if (load_valid) begin
        m_img[m_count] = load_data;
        m_count++;
        if (load_last || m_count == DEPTH) begin
          m_len = m_count;
          m_mode = 2;
        end
      end
    end else if (m_mode == 2 && fetch_req) begin
      m_ack = 1'b1;
      if (a < m_len) begin
        m_data = m_img[a]; m_oob = 1'b0;
      end else begin
        m_data = NOP; m_oob = 1'b1;
      end
    end else begin
      m_ack = 1'b0; m_oob = 1'b0;
    end
  endtask

  task automatic step(input string tag, input logic ls, input logic lv, input logic [7:0] ld,
                      input logic ll, input logic fr, input logic [7:0] fa);
    @(negedge clk);
    load_start = ls; load_valid = lv; load_data = ld; load_last = ll;
    fetch_req = fr; fetch_addr = fa;
    @(posedge clk);
    model_clock();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] w;
    model_reset();
    #1;
    check_all("por");
    #20;
    rst_n = 1'b1;

    // Activity before any load_start is ignored.
    step("empty_lv", 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 8'h00);
    step("empty_fr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01);

    // Four-word image, then back-to-back fetches and out-of-range fetch.
    step("ld4_start", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step("ld4_w0", 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00);
    step("ld4_w1", 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00);
    step("ld4_w2", 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
    step("ld4_w3", 1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step("f4_seq", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'(i));
    step("f4_oob7", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h07);
    step("f4_addr3", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03);
    idle("f4_hold");
    chk("f4_fixed_data", 32'(fetch_data), 32'h44);

    // Full-depth image without load_last.
    step("full_start", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step("full_w", 1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
    idle("full_run");
    chk("full_len", 32'(prog_len), 32'd256);
    step("full_f255", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF);
    chk("full_f255_data", 32'(fetch_data), 32'hFF);
    for (int i = 0; i < 40; i++)
      step("full_rnd", 1'b0, 1'b0, 8'h00, 1'b0, 1'($urandom), 8'($urandom));

    // Reload in RUN coinciding with a fetch: no ack.
    step("rl_start", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    step("rl_a5", 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'h00);
    step("rl_f0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    step("rl_f1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01);

    // Restart in LOAD drops the same-cycle beat.
    step("rs_start", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step("rs_w0", 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00);
    step("rs_again", 1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 8'h00);
    step("rs_w1", 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00);
    step("rs_f0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);

    // Async reset partway through a load, then stimulus ignored until load_start.
    step("mr_start", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step("mr_w0", 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00);
    step("mr_w1", 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 8'h00);
    async_reset("mr_rst");
    step("mr_lv", 1'b0, 1'b1, 8'h30, 1'b1, 1'b1, 8'h00);
    step("mr_fr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);

    // Gapped load 1,0,0,1,1 with last on the final beat.
    step("gap_start", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step("gap_v1", 1'b0, 1'b1, 8'hC1, 1'b0, 1'b0, 8'h00);
    step("gap_v0", 1'b0, 1'b0, 8'hD0, 1'b0, 1'b0, 8'h00);
    step("gap_v0", 1'b0, 1'b0, 8'hD1, 1'b1, 1'b0, 8'h00);
    step("gap_v1", 1'b0, 1'b1, 8'hC2, 1'b0, 1'b0, 8'h00);
    step("gap_v1", 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step("gap_f", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'(i));

    // Fully randomized traffic, including reset during fetches.
    for (int i = 0; i < 600; i++) begin
      w = 8'($urandom);
      if (i == 300) async_reset("rnd_rst");
      step("rnd", ($urandom_range(0, 59) == 0), 1'($urandom), w,
           ($urandom_range(0, 9) == 0), 1'($urandom), 8'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
